// File: rtl/axi_burst_write_master.sv
// AXI4 INCR burst writer: drains a read-ahead FIFO into memory and splits bursts at MAX_BURST beats and at 4 KB pages.
// One burst in flight at a time; tail-beat strobes are byte-accurate and error is sticky per transfer.
module axi_burst_write_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int SIZE_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [SIZE_W-1:0]   transfer_size,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                empty,
  output logic                rd_en,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int SW1   = SIZE_W + 1;
  localparam logic [SIZE_W-1:0] ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] cur_addr;
  logic [SIZE_W-1:0] aw_left, fetch_left, send_left, total_beats;
  logic [SW1-1:0]    size_ext;
  logic [8:0]        burst_beats, burst_len, w_cnt;
  logic [12:0]       page_bytes, page_beats;
  logic [31:0]       lim;
  logic [BSH-1:0]    tail;
  logic [BYTES-1:0]  tail_mask;
  logic              err_q;

  logic [DATA_W-1:0] buf_mem [2];
  logic              wr_ptr, rd_ptr, rd_pend;
  logic [1:0]        buf_cnt;
  logic              pop, aw_hs, accept;

  assign size_ext    = {1'b0, transfer_size} + SW1'(BYTES - 1);
  assign total_beats = SIZE_W'(size_ext >> BSH);
  assign page_bytes  = 13'h1000 - {1'b0, cur_addr[11:0]};
  assign page_beats  = page_bytes >> BSH;

  always_comb begin
    lim = 32'(MAX_BURST);
    if (32'(aw_left) < lim)    lim = 32'(aw_left);
    if (32'(page_beats) < lim) lim = 32'(page_beats);
    burst_beats = 9'(lim);
  end

  always_comb begin
    tail_mask = '0;
    for (int i = 0; i < BYTES; i++) tail_mask[i] = (BSH'(i) < tail);
  end

  assign awsize  = 3'(BSH);
  assign awburst = 2'b01;
  assign awaddr  = cur_addr;
  assign awlen   = (state == S_AW && aw_left != '0) ? 8'(burst_beats - 9'd1) : 8'd0;
  assign wvalid  = (state == S_W) && (buf_cnt != 2'd0);
  assign wdata   = buf_mem[rd_ptr];
  assign wlast   = wvalid && (w_cnt == burst_len - 9'd1);
  assign wstrb   = !wvalid ? '0 : ((send_left == ONE && tail != '0) ? tail_mask : '1);
  assign error   = err_q;
  assign pop     = wvalid && wready;
  assign aw_hs   = awvalid && awready;
  assign accept  = (state == S_IDLE) && start;

  // A beat already requested from the FIFO counts against the two buffer slots.
  assign rd_en = !empty && (fetch_left != '0) &&
                 (({1'b0, buf_cnt} + {2'b0, rd_pend} - {2'b0, pop}) < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    bready    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_AW;
      S_AW: begin
        busy    = 1'b1;
        awvalid = (aw_left != '0);
        if (aw_left == '0) state_nxt = S_DONE;
        else if (awready)  state_nxt = S_W;
      end
      S_W: begin
        busy = 1'b1;
        if (pop && wlast) state_nxt = S_B;
      end
      S_B: begin
        busy   = 1'b1;
        bready = 1'b1;
        if (bvalid) state_nxt = (aw_left != '0) ? S_AW : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      aw_left    <= '0;
      fetch_left <= '0;
      send_left  <= '0;
      tail       <= '0;
      burst_len  <= '0;
      w_cnt      <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      cur_addr   <= addr & ~ADDR_W'(BYTES - 1);
      aw_left    <= total_beats;
      fetch_left <= total_beats;
      send_left  <= total_beats;
      tail       <= transfer_size[BSH-1:0];
      err_q      <= 1'b0;
    end else begin
      if (aw_hs) begin
        cur_addr  <= cur_addr + (ADDR_W'(burst_beats) << BSH);
        aw_left   <= aw_left - SIZE_W'(burst_beats);
        burst_len <= burst_beats;
        w_cnt     <= '0;
      end
      if (pop) begin
        w_cnt     <= w_cnt + 9'd1;
        send_left <= send_left - ONE;
      end
      if (rd_en)                        fetch_left <= fetch_left - ONE;
      if (bready && bvalid && bresp != 2'b00) err_q <= 1'b1;
    end
  end

  // FIFO data lands one cycle after the pop, so the write side follows rd_pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      rd_pend    <= 1'b0;
      buf_cnt    <= 2'd0;
    end else begin
      rd_pend <= rd_en;
      if (rd_pend) begin
        buf_mem[wr_ptr] <= data_in;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Randomised bench for axi_burst_write_master: a FIFO model and AXI slave drive the DUT while a
// reference burst plan computed from plain arithmetic scores every AW, W and B transfer.
module tb_axi_burst_write_master;
  localparam int ADDR_W = 32, DATA_W = 32, MAX_BURST = 16, SIZE_W = 16, BYTES = DATA_W / 8;

  logic clk = 1'b0;
  logic rst_n, start, awvalid, awready, wlast, wvalid, wready, bvalid, bready, empty, rd_en;
  logic busy, done, error;
  logic [31:0] addr, awaddr, wdata, data_in;
  logic [15:0] transfer_size;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi_burst_write_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .transfer_size(transfer_size),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .data_in(data_in), .empty(empty), .rd_en(rd_en), .busy(busy), .done(done), .error(error));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_aw_addr[$], exp_wdata[$], obs_aw_addr[$], obs_wdata[$];
  logic [7:0]  exp_aw_len[$], obs_aw_len[$];
  logic [3:0]  exp_wstrb[$], obs_wstrb[$];
  logic        exp_wlast[$], obs_wlast[$];
  int res_done_cyc, res_pops, res_aws, res_err;

  // Reference plan: walk the transfer beat by beat, cutting at MAX_BURST and page ends.
  task automatic build_model(input logic [31:0] a, input logic [15:0] sz);
    int total, rem, k, b, room;
    logic [31:0] cur;
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_wdata.delete(); exp_wstrb.delete(); exp_wlast.delete();
    total = (int'(sz) + BYTES - 1) / BYTES;
    cur   = a & ~32'(BYTES - 1);
    rem   = total;
    k     = 0;
    while (rem > 0) begin
      room = (4096 - int'(cur % 4096)) / BYTES;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room)      b = room;
      exp_aw_addr.push_back(cur);
      exp_aw_len.push_back(8'(b - 1));
      for (int j = 0; j < b; j++) begin
        exp_wdata.push_back(fifo_q[k]);
        exp_wstrb.push_back((k == total - 1 && sz % BYTES != 0) ? 4'((1 << (sz % BYTES)) - 1) : 4'hF);
        exp_wlast.push_back(j == b - 1);
        k++;
      end
      cur += 32'(b * BYTES);
      rem -= b;
    end
  endtask

  task automatic fill_fifo(input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
  endtask

  // mode: 0 = readies high, 1 = readies toggle, 2 = random readies
  task automatic run_xfer(input logic [31:0] a, input logic [15:0] sz, input int mode,
                          input int stall_from, input int err_burst, input int abort_beats);
    int cyc, b_idx, total, exp_nb, beats;
    bit rd_prev, done_seen, bv, b_pending, w_open, stall_aw, stall_w, exp_err;
    logic [31:0] pend, h_awaddr, h_wdata, e_a, e_d;
    logic [7:0]  h_awlen, e_l;
    logic [3:0]  h_wstrb, e_s;
    logic        h_wlast, e_w;
    build_model(a, sz);
    total = (int'(sz) + BYTES - 1) / BYTES;
    exp_nb = exp_aw_addr.size();
    obs_aw_addr.delete(); obs_aw_len.delete(); obs_wdata.delete(); obs_wstrb.delete(); obs_wlast.delete();
    cyc = 0; b_idx = 0; beats = 0; pend = '0;
    rd_prev = 0; done_seen = 0; bv = 0; b_pending = 0; w_open = 0; stall_aw = 0; stall_w = 0;
    h_awaddr = '0; h_wdata = '0; h_awlen = '0; h_wstrb = '0; h_wlast = 0;
    res_done_cyc = -1; res_pops = 0; res_aws = 0; res_err = -1;
    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      start         = (cyc == 0) || (cyc == 3 && sz != 0);
      addr          = (cyc == 0) ? a : a ^ 32'h40;
      transfer_size = (cyc == 0) ? sz : sz + 16'd8;
      data_in       = rd_prev ? pend : $urandom;
      empty = (fifo_q.size() == 0) || (stall_from >= 0 && cyc >= stall_from && cyc < stall_from + 5);
      case (mode)
        0:       begin awready = 1'b1;        wready = 1'b1; end
        1:       begin awready = (cyc % 2 == 1); wready = (cyc % 2 == 0); end
        default: begin awready = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1)); end
      endcase
      if (b_pending && !bv && (mode == 0 || $urandom_range(0, 1) == 1)) bv = 1;
      bvalid = bv;
      bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (cyc == 1) begin
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL error_clear_on_start: got %b expected 0", error); end
      end
      if (stall_aw) begin
        n_checks++;
        if (awvalid !== 1'b1 || awaddr !== h_awaddr || awlen !== h_awlen) begin
          n_fail++; $display("FAIL aw_stable: got v=%b a=%h l=%0d expected v=1 a=%h l=%0d", awvalid, awaddr, awlen, h_awaddr, h_awlen);
        end
      end
      if (stall_w) begin
        n_checks++;
        if (wvalid !== 1'b1 || wdata !== h_wdata || wstrb !== h_wstrb || wlast !== h_wlast) begin
          n_fail++; $display("FAIL w_stable: got v=%b d=%h s=%h l=%b expected v=1 d=%h s=%h l=%b", wvalid, wdata, wstrb, wlast, h_wdata, h_wstrb, h_wlast);
        end
      end
      if (rd_en === 1'b1) begin
        n_checks++;
        if (empty || fifo_q.size() == 0) begin n_fail++; $display("FAIL rd_en_empty: rd_en=1 with empty=%b at cycle %0d", empty, cyc); end
        else begin pend = fifo_q.pop_front(); res_pops++; end
      end
      rd_prev = (rd_en === 1'b1);
      if (bready === 1'b1) begin
        n_checks++;
        if (!b_pending) begin n_fail++; $display("FAIL bready_early: got bready=1 expected 0 at cycle %0d", cyc); end
      end
      if (awvalid && awready) begin
        res_aws++;
        obs_aw_addr.push_back(awaddr); obs_aw_len.push_back(awlen);
        n_checks++;
        if (w_open || b_pending) begin n_fail++; $display("FAIL aw_outstanding: got second AW before B at cycle %0d expected none", cyc); end
        n_checks++;
        if (exp_aw_addr.size() == 0) begin n_fail++; $display("FAIL aw_extra: got addr=%h len=%0d expected no burst", awaddr, awlen); end
        else begin
          e_a = exp_aw_addr.pop_front(); e_l = exp_aw_len.pop_front();
          if (awaddr !== e_a || awlen !== e_l) begin
            n_fail++; $display("FAIL aw_burst: got addr=%h len=%0d expected addr=%h len=%0d", awaddr, awlen, e_a, e_l);
          end
        end
        w_open = 1;
      end
      if (wvalid && wready) begin
        beats++;
        obs_wdata.push_back(wdata); obs_wstrb.push_back(wstrb); obs_wlast.push_back(wlast);
        n_checks++;
        if (exp_wdata.size() == 0) begin n_fail++; $display("FAIL w_extra: got data=%h expected no beat", wdata); end
        else begin
          e_d = exp_wdata.pop_front(); e_s = exp_wstrb.pop_front(); e_w = exp_wlast.pop_front();
          if (wdata !== e_d || wstrb !== e_s || wlast !== e_w) begin
            n_fail++; $display("FAIL w_beat %0d: got d=%h s=%h l=%b expected d=%h s=%h l=%b", beats, wdata, wstrb, wlast, e_d, e_s, e_w);
          end
        end
        if (wlast) begin b_pending = 1; w_open = 0; end
      end
      if (bvalid && bready) begin b_pending = 0; bv = 0; b_idx++; end
      stall_aw = awvalid && !awready;
      stall_w  = wvalid && !wready;
      h_awaddr = awaddr; h_awlen = awlen; h_wdata = wdata; h_wstrb = wstrb; h_wlast = wlast;
      if (done === 1'b1) begin
        done_seen = 1; res_done_cyc = cyc; res_err = int'(error);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got busy=%b expected 0", busy); end
      end else if (cyc >= 1) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during: got %b expected 1 at cycle %0d", busy, cyc); end
      end
      if (abort_beats > 0 && beats >= abort_beats) return;
      cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (!done_seen) begin n_fail++; $display("FAIL done_timeout: got no done expected done within 4000 cycles"); end
    n_checks++;
    if (res_pops != total) begin n_fail++; $display("FAIL pop_count: got %0d expected %0d", res_pops, total); end
    n_checks++;
    if (exp_wdata.size() != 0 || exp_aw_addr.size() != 0) begin
      n_fail++; $display("FAIL missing_traffic: got %0d beats/%0d bursts unsent expected 0", exp_wdata.size(), exp_aw_addr.size());
    end
    n_checks++;
    if (awsize !== 3'd2 || awburst !== 2'b01) begin n_fail++; $display("FAIL aw_consts: got %0d/%b expected 2/01", awsize, awburst); end
    exp_err = (err_burst >= 0 && err_burst < exp_nb);
    n_checks++;
    if (res_err != int'(exp_err)) begin n_fail++; $display("FAIL error_flag: got %0d expected %0d", res_err, exp_err); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; addr = '0; transfer_size = '0; awready = 0; wready = 0;
    bvalid = 0; bresp = '0; empty = 1; data_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({awvalid, wvalid, bready, rd_en, busy, done, error, wlast} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000", {awvalid, wvalid, bready, rd_en, busy, done, error, wlast});
    end
    n_checks++;
    if (awaddr !== '0 || awlen !== '0 || wdata !== '0 || wstrb !== '0) begin
      n_fail++; $display("FAIL reset_data: got a=%h l=%h d=%h s=%h expected all 0", awaddr, awlen, wdata, wstrb);
    end
    n_checks++;
    if (awsize !== 3'd2 || awburst !== 2'b01) begin n_fail++; $display("FAIL reset_consts: got %0d/%b expected 2/01", awsize, awburst); end
    rst_n = 1'b1;
  endtask

  task automatic test_legacy;
    fifo_q.delete();
    fifo_q.push_back(32'hDEADBEEF); fifo_q.push_back(32'h12345678);
    fifo_q.push_back(32'hAAAA5555); fifo_q.push_back(32'h5555AAAA);
    run_xfer(32'h0, 16'd8, 0, -1, -1, 0);
    n_checks++;
    if (obs_aw_addr.size() != 1 || obs_aw_addr[0] !== 32'h0 || obs_aw_len[0] !== 8'd1) begin
      n_fail++; $display("FAIL legacy_aw: got %0d bursts expected 1 at 0 len 1", obs_aw_addr.size());
    end
    n_checks++;
    if (obs_wdata.size() != 2 || obs_wdata[0] !== 32'hDEADBEEF || obs_wdata[1] !== 32'h12345678 ||
        obs_wstrb[1] !== 4'hF || obs_wlast[0] !== 1'b0 || obs_wlast[1] !== 1'b1) begin
      n_fail++; $display("FAIL legacy_w: got %0d beats expected DEADBEEF,12345678 wlast on beat 2", obs_wdata.size());
    end
  endtask

  task automatic test_split;
    fill_fifo(20);
    run_xfer(32'h100, 16'd70, 2, -1, -1, 0);
    n_checks++;
    if (obs_aw_addr.size() != 2 || obs_aw_addr[0] !== 32'h100 || obs_aw_len[0] !== 8'd15 ||
        obs_aw_addr[1] !== 32'h140 || obs_aw_len[1] !== 8'd1) begin
      n_fail++; $display("FAIL split_bursts: got %0d bursts expected (100,15)(140,1)", obs_aw_addr.size());
    end
    n_checks++;
    if (obs_wstrb.size() != 18 || obs_wstrb[17] !== 4'b0011) begin
      n_fail++; $display("FAIL split_tail: got %0d beats expected 18 ending strb 0011", obs_wstrb.size());
    end
  endtask

  task automatic test_4k_cross;
    int nl;
    fill_fifo(10);
    run_xfer(32'hFF8, 16'd32, 0, -1, -1, 0);
    n_checks++;
    if (obs_aw_addr.size() != 2 || obs_aw_addr[0] !== 32'hFF8 || obs_aw_len[0] !== 8'd1 ||
        obs_aw_addr[1] !== 32'h1000 || obs_aw_len[1] !== 8'd5) begin
      n_fail++; $display("FAIL 4k_bursts: got %0d bursts expected (FF8,1)(1000,5)", obs_aw_addr.size());
    end
    nl = 0;
    foreach (obs_wlast[i]) nl += int'(obs_wlast[i]);
    n_checks++;
    if (obs_wlast.size() != 8 || nl != 2 || obs_wlast[1] !== 1'b1 || obs_wlast[7] !== 1'b1) begin
      n_fail++; $display("FAIL 4k_wlast: got %0d beats %0d wlast expected 8 beats wlast on 2 and 8", obs_wlast.size(), nl);
    end
  endtask

  task automatic test_backpressure;
    fill_fifo(12);
    run_xfer(32'h200, 16'd40, 1, 4, -1, 0);
    n_checks++;
    if (fifo_q.size() != 2) begin n_fail++; $display("FAIL bp_extra_pops: got %0d left expected 2", fifo_q.size()); end
  endtask

  task automatic test_error;
    fill_fifo(22);
    run_xfer(32'h0, 16'd80, 2, -1, 0, 0);
    n_checks++;
    if (res_aws != 2) begin n_fail++; $display("FAIL err_second_burst: got %0d bursts expected 2", res_aws); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", error); end
    fill_fifo(6);
    run_xfer(32'h0, 16'd16, 0, -1, -1, 0);
  endtask

  task automatic test_zero_size;
    fill_fifo(2);
    run_xfer(32'h40, 16'd0, 0, -1, -1, 0);
    n_checks++;
    if (res_done_cyc != 2) begin n_fail++; $display("FAIL zero_done_timing: got cycle %0d expected 2", res_done_cyc); end
    n_checks++;
    if (res_aws != 0 || res_pops != 0 || obs_wdata.size() != 0) begin
      n_fail++; $display("FAIL zero_traffic: got aw=%0d pops=%0d beats=%0d expected 0", res_aws, res_pops, obs_wdata.size());
    end
  endtask

  task automatic test_reset_mid_w;
    fill_fifo(18);
    run_xfer(32'h300, 16'd64, 0, -1, -1, 3);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({awvalid, wvalid, bready, rd_en, busy, done, error, wlast} !== 8'h00) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b expected 00000000", {awvalid, wvalid, bready, rd_en, busy, done, error, wlast});
    end
    n_checks++;
    if (awaddr !== '0 || awlen !== '0 || wdata !== '0 || wstrb !== '0) begin
      n_fail++; $display("FAIL midreset_data: got a=%h l=%h d=%h s=%h expected all 0", awaddr, awlen, wdata, wstrb);
    end
    @(negedge clk);
    start = 0; bvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_fifo(18);
    run_xfer(32'h300, 16'd64, 0, -1, -1, 0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [15:0] sz;
    int nb;
    for (int t = 0; t < 6; t++) begin
      a  = 32'hF00 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
      sz = 16'($urandom_range(0, 200));
      nb = (int'(sz) + BYTES - 1) / BYTES;
      fill_fifo(nb + 2);
      run_xfer(a, sz, 2, (t % 2 == 0) ? int'($urandom_range(3, 20)) : -1, int'($urandom_range(0, 3)) - 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_split();
    test_4k_cross();
    test_backpressure();
    test_error();
    test_zero_size();
    test_reset_mid_w();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
